// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive front end.
// PS/2 frames are 11 bits: start 0, eight data bits LSB first, odd parity, stop 1.
package ps2_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } ps2_state_e;

  localparam int unsigned FrameBits = 11;
  localparam int unsigned DataBits  = 8;
  localparam bit          OddParity = 1'b1;

  localparam int unsigned DefFilterLen     = 8;
  localparam int unsigned DefTimeoutCycles = 200000;
  localparam int unsigned DefFifoDepth     = 8;

  function automatic logic parity_ok(input logic [DataBits-1:0] data, input logic par_bit);
    return (^{data, par_bit}) == OddParity;
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// First-word-fall-through byte FIFO with occupancy count and overflow strobe.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module ps2_rx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == (AW+1)'(DEPTH));
  assign o_count    = r_count;
  assign w_do_pop   = i_pop & ~o_empty;
  assign w_do_push  = i_push & (~o_full | w_do_pop);
  assign o_overflow = i_push & o_full & ~w_do_pop;
  assign o_rd_data  = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers are exactly AW bits wide so they wrap modulo DEPTH on their own.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_rx_frontend.sv
// PS/2 device-to-host receiver: pad synchronizers, glitch filters, frame FSM with
// timeout, sticky error flags and a FWFT byte FIFO toward the register block.
module ps2_rx_frontend
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = DefFilterLen,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
  parameter int unsigned FIFO_DEPTH     = DefFifoDepth
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic                          ps2_clk_i,
  input  logic                          ps2_data_i,
  input  logic                          rd_en_i,
  output logic [7:0]                    rd_data_o,
  output logic                          empty_o,
  output logic                          full_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          parity_err_o,
  output logic                          frame_err_o,
  output logic                          overflow_o,
  input  logic                          clr_err_i,
  output logic                          irq_o
);

  localparam int unsigned FltW = $clog2(FILTER_LEN) + 1;
  localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FltW-1:0] FltMax = FltW'(FILTER_LEN - 1);
  localparam logic [ToW-1:0]  ToMax  = ToW'(TIMEOUT_CYCLES - 1);

  // Index 0 carries the PS/2 clock, index 1 the PS/2 data.
  logic [1:0]       r_sync0;
  logic [1:0]       r_sync1;
  logic [1:0]       r_filt;
  logic [FltW-1:0]  r_flt_cnt [2];
  logic             r_clk_prev;
  logic             w_fall;
  logic             w_data;

  ps2_state_e        r_state, w_state_nxt;
  logic [2:0]        r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]        r_shift, w_shift_nxt;
  logic              r_par_ok, w_par_ok_nxt;
  logic [ToW-1:0]    r_timeout, w_timeout_nxt;
  logic              r_push, w_push_nxt;
  logic              w_set_par;
  logic              w_set_frm;
  logic              w_ovf;

  logic              r_par_err;
  logic              r_frm_err;
  logic              r_ovf_err;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_sync0      <= '1;
      r_sync1      <= '1;
      r_filt       <= '1;
      r_flt_cnt[0] <= '0;
      r_flt_cnt[1] <= '0;
      r_clk_prev   <= 1'b1;
    end else begin
      r_sync0    <= {ps2_data_i, ps2_clk_i};
      r_sync1    <= r_sync0;
      r_clk_prev <= r_filt[0];
      // The filtered level flips only after FILTER_LEN consecutive differing samples.
      for (int i = 0; i < 2; i++) begin
        if (r_sync1[i] != r_filt[i]) begin
          if (r_flt_cnt[i] == FltMax) begin
            r_filt[i]    <= r_sync1[i];
            r_flt_cnt[i] <= '0;
          end else begin
            r_flt_cnt[i] <= r_flt_cnt[i] + 1'b1;
          end
        end else begin
          r_flt_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_fall = r_clk_prev & ~r_filt[0];
  assign w_data = r_filt[1];

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_par_ok_nxt  = r_par_ok;
    w_push_nxt    = 1'b0;
    w_set_par     = 1'b0;
    w_set_frm     = 1'b0;

    if (r_state == StIdle || w_fall) begin
      w_timeout_nxt = '0;
    end else begin
      w_timeout_nxt = r_timeout + 1'b1;
    end

    unique case (r_state)
      StIdle: begin
        if (w_fall && !w_data) begin
          w_state_nxt   = StData;
          w_bit_cnt_nxt = '0;
        end
      end
      StData: begin
        if (w_fall) begin
          w_shift_nxt = {w_data, r_shift[7:1]};
          if (r_bit_cnt == 3'(DataBits - 1)) begin
            w_state_nxt = StParity;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
      StParity: begin
        if (w_fall) begin
          w_par_ok_nxt = parity_ok(r_shift, w_data);
          w_state_nxt  = StStop;
        end
      end
      StStop: begin
        if (w_fall) begin
          if (!w_data) begin
            w_set_frm = 1'b1;
          end else if (!r_par_ok) begin
            w_set_par = 1'b1;
          end else begin
            w_push_nxt = 1'b1;
          end
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    if (r_state != StIdle && !w_fall && r_timeout == ToMax) begin
      w_state_nxt   = StIdle;
      w_set_frm     = 1'b1;
      w_timeout_nxt = '0;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state   <= StIdle;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par_ok  <= 1'b0;
      r_timeout <= '0;
      r_push    <= 1'b0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
      r_ovf_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_par_ok  <= w_par_ok_nxt;
      r_timeout <= w_timeout_nxt;
      r_push    <= w_push_nxt;
      // A setting event in the same cycle as a clear keeps the flag set.
      r_par_err <= w_set_par | (r_par_err & ~clr_err_i);
      r_frm_err <= w_set_frm | (r_frm_err & ~clr_err_i);
      r_ovf_err <= w_ovf     | (r_ovf_err & ~clr_err_i);
    end
  end

  // r_shift is untouched in IDLE, so it still holds the byte when r_push fires.
  ps2_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DataBits)
  ) u_fifo (
    .i_clk      (ACLK),
    .i_rst      (ARESET),
    .i_push     (r_push),
    .i_wr_data  (r_shift),
    .i_pop      (rd_en_i),
    .o_rd_data  (rd_data_o),
    .o_empty    (empty_o),
    .o_full     (full_o),
    .o_count    (count_o),
    .o_overflow (w_ovf)
  );

  assign parity_err_o = r_par_err;
  assign frame_err_o  = r_frm_err;
  assign overflow_o   = r_ovf_err;
  assign irq_o        = ~empty_o;

endmodule

// File: doc/ps2_rx_frontend.md
PS2_RX_FRONTEND -- requirements
Module: ps2_rx_frontend

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive identical synchronized samples required before the filtered PS/2 clock/data level changes.
REQ-002 Parameter TIMEOUT_CYCLES, default 200000: ACLK cycles without a PS/2 falling edge that abort a frame in progress (2 ms at 100 MHz).
REQ-003 Parameter FIFO_DEPTH, default 8: received-byte FIFO depth; power of two, minimum 2.
REQ-004 ACLK  in  1  single system clock; all logic on the rising edge.
REQ-005 ARESET  in  1  asynchronous, active-high reset.
REQ-006 ps2_clk_i  in  1  raw PS/2 clock from the pad; asynchronous to ACLK.
REQ-007 ps2_data_i  in  1  raw PS/2 data from the pad; asynchronous to ACLK.
REQ-008 rd_en_i  in  1  pop strobe from the AXI register block; one byte per cycle high.
REQ-009 rd_data_o  out  8  FIFO head byte, first-word-fall-through.
REQ-010 empty_o  out  1  FIFO holds no bytes.
REQ-011 full_o  out  1  FIFO holds FIFO_DEPTH bytes.
REQ-012 count_o  out  clog2(FIFO_DEPTH)+1  bytes currently held.
REQ-013 parity_err_o / frame_err_o / overflow_o  out  1 each  sticky error flags.
REQ-014 clr_err_i  in  1  clears all three sticky flags.
REQ-015 irq_o  out  1  level interrupt, equals !empty_o.

Function
REQ-016 Each pad input passes through a 2-flop synchronizer, then a glitch filter; filtered level changes only after FILTER_LEN equal consecutive samples.
REQ-017 A falling edge is the filtered clock going 1->0; data is sampled from filtered data in the cycle the edge is detected.
REQ-018 The FSM has states IDLE, DATA, PARITY, STOP.
REQ-019 IDLE: on a falling edge with data 0 (start bit), go to DATA with bit counter 0; with data 1, stay in IDLE, no flag.
REQ-020 DATA: shift sampled bits LSB first; after the 8th bit go to PARITY.
REQ-021 PARITY: capture bit; parity OK when the XOR of 8 data bits and the parity bit is 1 (odd parity); go to STOP.
REQ-022 STOP: stop bit 1 with parity OK -> push byte; stop bit 0 -> set frame_err_o, discard; parity bad with stop 1 -> set parity_err_o, discard; always return to IDLE.
REQ-023 Push occurs in the cycle after stop-bit sampling; empty_o deasserts and count_o increments the following cycle.
REQ-024 Timeout counter resets on every falling edge and holds 0 in IDLE; reaching TIMEOUT_CYCLES outside IDLE -> IDLE, set frame_err_o, discard partial byte.
REQ-025 rd_en_i with empty_o=1 is ignored, no state change.
REQ-026 Push with FIFO full and no simultaneous pop -> byte dropped, overflow_o set; FIFO contents unchanged.
REQ-027 Simultaneous push and pop, including when full: both succeed, count_o unchanged.
REQ-028 Read/write pointers wrap modulo FIFO_DEPTH; count_o distinguishes full from empty.
REQ-029 clr_err_i clears flags next cycle; a flag-setting event in the same cycle wins (flag stays 1).
REQ-030 Receiver is receive-only; never drives PS/2 lines.

Reset
REQ-031 ARESET asserted: FSM->IDLE, FIFO emptied (empty_o=1, full_o=0, count_o=0), rd_data_o=0, all error flags 0, irq_o=0, synchronizer and filter outputs 1 (bus idle), timeout counter 0.
REQ-032 Reset mid-frame discards the partial byte; the first frame completed after release is accepted normally.

Structure
REQ-033 Shared package ps2_pkg holds the FSM state enum, PS/2 frame constants (11 bits, odd parity) and default parameter values.
REQ-034 FIFO is sub-module ps2_rx_fifo (FWFT, parameterized depth); synchronizer, filter, FSM stay in ps2_rx_frontend.

Verification
REQ-035 Frame 0x1C, parity 0, stop 1, PS/2 clock 12.5 kHz -> rd_data_o=0x1C, count_o=1, irq_o=1, no flags.
REQ-036 Frame 0xF0 with parity bit 0 (wrong) -> FIFO stays empty, parity_err_o=1; clr_err_i pulse -> 0.
REQ-037 Frame 0x5A with stop 0 -> discarded, frame_err_o=1; start then only 4 edges then silence -> frame_err_o=1 after TIMEOUT_CYCLES, next valid 0x29 accepted.
REQ-038 9 frames (0x01..0x09), no reads, DEPTH 8 -> full_o=1, overflow_o=1, pops return 0x01..0x08 then empty_o=1.
REQ-039 1-cycle 0 glitches on ps2_clk_i every 50 cycles during frame 0x33 -> byte 0x33 received, no flags.
REQ-040 ARESET pulsed after bit 4 of a frame -> all outputs at reset values; following frame 0x45 received correctly.
